alu_result_checker: RTL and testbench

Synchronous self-checking monitor for the 32-bit ALU, the consuming end of the ALU stimulus interface. It samples each applied vector (A, B, FS, C0) with the ALU's combinational response (F, status), computes the expected result with an internal golden model, and compares the two. It keeps vector, error and skip counts, captures the first failing vector, and reports a pass/fail verdict at the end of a run. It sits beside the ALU in benches and on-chip BIST wrappers.

---
 rtl/alu_result_checker.sv | 204 ++++++++++++++++++++
 tb/tb_alu_result_checker.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// rtl/alu_result_checker.sv - self-checking monitor comparing ALU responses against a golden model
// Two-stage pipeline: stage 1 registers the vector, stage 2 compares and updates counters.
module alu_result_checker #(
   parameter int ERR_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             valid,
   input  logic             last,
   input  logic [31:0]      A,
   input  logic [31:0]      B,
   input  logic [2:0]       FS,
   input  logic             C0,
   input  logic [31:0]      F,
   input  logic [3:0]       status,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] vec_cnt,
   output logic [ERR_W-1:0] err_cnt,
   output logic [ERR_W-1:0] skip_cnt,
   output logic [31:0]      fail_vec,
   output logic [31:0]      fail_F,
   output logic [31:0]      fail_exp
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [ERR_W-1:0] CNT_MAX = '1;

   state_t            r_state;
   state_t            w_next_state;
   logic              r_drain_cnt;

   logic              w_accept;
   logic              r_s1_valid;
   logic [31:0]       r_s1_a;
   logic [31:0]       r_s1_b;
   logic [2:0]        r_s1_fs;
   logic              r_s1_c0;
   logic [31:0]       r_s1_f;
   logic [3:0]        r_s1_status;

   logic [32:0]       w_sum;
   logic [31:0]       w_exp_f;
   logic              w_exp_c;
   logic              w_exp_v;
   logic [3:0]        w_exp_status;
   logic              w_skip;
   logic              w_mismatch;

   logic [ERR_W-1:0]  r_vec_cnt;
   logic [ERR_W-1:0]  r_err_cnt;
   logic [ERR_W-1:0]  r_skip_cnt;
   logic              r_have_fail;
   logic [31:0]       r_fail_vec;
   logic [31:0]       r_fail_f;
   logic [31:0]       r_fail_exp;

   // A start in the same cycle as a vector wins and the vector is dropped.
   assign w_accept = valid && (r_state == S_RUN) && !start;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (start) begin
         w_next_state = S_RUN;
      end else begin
         case (r_state)
            S_IDLE:  w_next_state = S_IDLE;
            S_RUN:   if (valid && last) w_next_state = S_DRAIN;
            S_DRAIN: if (r_drain_cnt) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_DONE;
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      pass = 1'b0;
      case (r_state)
         S_RUN:   busy = 1'b1;
         S_DRAIN: busy = 1'b1;
         S_DONE:  begin
            done = 1'b1;
            pass = (r_err_cnt == '0);
         end
         default: busy = 1'b0;
      endcase
   end

   // Two DRAIN cycles: the first lets the final stage-2 update land.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_drain_cnt <= 1'b0;
      end else if (r_state == S_DRAIN) begin
         r_drain_cnt <= 1'b1;
      end else begin
         r_drain_cnt <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || start) begin
         r_s1_valid <= 1'b0;
      end else begin
         r_s1_valid <= w_accept;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_a      <= '0;
         r_s1_b      <= '0;
         r_s1_fs     <= '0;
         r_s1_c0     <= 1'b0;
         r_s1_f      <= '0;
         r_s1_status <= '0;
      end else if (w_accept) begin
         r_s1_a      <= A;
         r_s1_b      <= B;
         r_s1_fs     <= FS;
         r_s1_c0     <= C0;
         r_s1_f      <= F;
         r_s1_status <= status;
      end
   end

   always_comb begin
      w_sum   = {1'b0, r_s1_a} + {1'b0, r_s1_b} + {32'd0, r_s1_c0};
      w_exp_f = '0;
      w_exp_c = 1'b0;
      w_exp_v = 1'b0;
      case (r_s1_fs)
         3'b000: w_exp_f = r_s1_a & r_s1_b;
         3'b001: w_exp_f = r_s1_a | r_s1_b;
         3'b010: w_exp_f = r_s1_a ^ r_s1_b;
         3'b011: w_exp_f = ~(r_s1_a | r_s1_b);
         3'b100: begin
            w_exp_f = w_sum[31:0];
            w_exp_c = w_sum[32];
            w_exp_v = (r_s1_a[31] == r_s1_b[31]) && (w_sum[31] != r_s1_a[31]);
         end
         3'b101: w_exp_f = r_s1_a << r_s1_b[4:0];
         3'b110: w_exp_f = r_s1_a >> r_s1_b[4:0];
         default: w_exp_f = '0;
      endcase
   end

   assign w_exp_status = {w_exp_v, w_exp_c, w_exp_f[31], (w_exp_f == 32'd0)};
   assign w_skip       = (r_s1_fs == 3'b111);
   assign w_mismatch   = (r_s1_f != w_exp_f) || (r_s1_status != w_exp_status);

   always_ff @(posedge clk) begin
      if (rst || start) begin
         r_vec_cnt   <= '0;
         r_err_cnt   <= '0;
         r_skip_cnt  <= '0;
         r_have_fail <= 1'b0;
         r_fail_vec  <= '0;
         r_fail_f    <= '0;
         r_fail_exp  <= '0;
      end else if (r_s1_valid) begin
         if (w_skip) begin
            if (r_skip_cnt != CNT_MAX) r_skip_cnt <= r_skip_cnt + 1'b1;
         end else begin
            if (r_vec_cnt != CNT_MAX) r_vec_cnt <= r_vec_cnt + 1'b1;
            if (w_mismatch) begin
               if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + 1'b1;
               // Only the first failure after start is kept for debug.
               if (!r_have_fail) begin
                  r_have_fail <= 1'b1;
                  r_fail_vec  <= 32'(r_vec_cnt);
                  r_fail_f    <= r_s1_f;
                  r_fail_exp  <= w_exp_f;
               end
            end
         end
      end
   end

   assign vec_cnt  = r_vec_cnt;
   assign err_cnt  = r_err_cnt;
   assign skip_cnt = r_skip_cnt;
   assign fail_vec = r_fail_vec;
   assign fail_F   = r_fail_f;
   assign fail_exp = r_fail_exp;

endmodule

// File: tb/tb_alu_result_checker.sv
// tb/tb_alu_result_checker.sv - directed and table-driven bench for alu_result_checker
module tb_alu_result_checker;

   logic        clk = 1'b0;
   logic        rst, start, valid, last, C0;
   logic [31:0] A, B, F;
   logic [2:0]  FS;
   logic [3:0]  status;

   logic        busy, done, pass;
   logic [15:0] vec_cnt, err_cnt, skip_cnt;
   logic [31:0] fail_vec, fail_F, fail_exp;

   logic        busy4, done4, pass4;
   logic [3:0]  vec_cnt4, err_cnt4, skip_cnt4;
   logic [31:0] fail_vec4, fail_F4, fail_exp4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_result_checker #(.ERR_W(16)) u_dut (
      .clk(clk), .rst(rst), .start(start), .valid(valid), .last(last),
      .A(A), .B(B), .FS(FS), .C0(C0), .F(F), .status(status),
      .busy(busy), .done(done), .pass(pass),
      .vec_cnt(vec_cnt), .err_cnt(err_cnt), .skip_cnt(skip_cnt),
      .fail_vec(fail_vec), .fail_F(fail_F), .fail_exp(fail_exp)
   );

   alu_result_checker #(.ERR_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start), .valid(valid), .last(last),
      .A(A), .B(B), .FS(FS), .C0(C0), .F(F), .status(status),
      .busy(busy4), .done(done4), .pass(pass4),
      .vec_cnt(vec_cnt4), .err_cnt(err_cnt4), .skip_cnt(skip_cnt4),
      .fail_vec(fail_vec4), .fail_F(fail_F4), .fail_exp(fail_exp4)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  fs;
      logic        c0;
      logic [31:0] f;
      logic [3:0]  st;
      logic        exp_pass;
   } vec_t;

   vec_t tbl [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] fs,
                        input logic c0, input logic [31:0] f, input logic [3:0] st, input logic lst);
      valid  = 1'b1;
      A      = a;
      B      = b;
      FS     = fs;
      C0     = c0;
      F      = f;
      status = st;
      last   = lst;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] fs,
                       input logic c0, input logic [31:0] f, input logic [3:0] st, input logic lst);
      drive(a, b, fs, c0, f, st, lst);
      tick();
      valid = 1'b0;
      last  = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      check(name, {31'd0, done}, 32'd1);
   endtask

   // Reference ALU result {V,C,N,Z,F} used for the random run.
   function automatic logic [35:0] golden(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] fs, input logic c0);
      logic [32:0] s;
      logic [31:0] f;
      logic        c, v;
      s = {1'b0, a} + {1'b0, b} + 33'(c0);
      c = 1'b0;
      v = 1'b0;
      case (fs)
         3'd0: f = a & b;
         3'd1: f = a | b;
         3'd2: f = a ^ b;
         3'd3: f = ~(a | b);
         3'd4: begin
            f = s[31:0];
            c = s[32];
            v = (a[31] == b[31]) && (f[31] != a[31]);
         end
         3'd5: f = a << b[4:0];
         3'd6: f = a >> b[4:0];
         default: f = 32'd0;
      endcase
      return {v, c, f[31], (f == 32'd0), f};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [35:0] g;
      logic [31:0] exp10;
      logic [31:0] ra, rb;
      logic [2:0]  rfs;
      logic        rc0;

      tbl[0]  = '{32'd15, 32'd10, 3'b000, 1'b0, 32'd10,         4'b0000, 1'b1};
      tbl[1]  = '{32'd15, 32'd10, 3'b001, 1'b0, 32'd15,         4'b0000, 1'b1};
      tbl[2]  = '{32'd15, 32'd10, 3'b010, 1'b0, 32'd5,          4'b0000, 1'b1};
      tbl[3]  = '{32'd15, 32'd10, 3'b011, 1'b0, 32'hFFFFFFF0,   4'b0010, 1'b1};
      tbl[4]  = '{32'h7FFFFFFF, 32'd1, 3'b100, 1'b0, 32'h80000000, 4'b1010, 1'b1};
      tbl[5]  = '{32'hFFFFFFFF, 32'd1, 3'b100, 1'b0, 32'd0,     4'b0101, 1'b1};
      tbl[6]  = '{32'd2, 32'd1, 3'b101, 1'b0, 32'd4,            4'b0000, 1'b1};
      tbl[7]  = '{32'd2, 32'd1, 3'b110, 1'b0, 32'd1,            4'b0000, 1'b1};
      tbl[8]  = '{32'd5, 32'd6, 3'b100, 1'b1, 32'd12,           4'b0000, 1'b1};
      tbl[9]  = '{32'd15, 32'd10, 3'b000, 1'b0, 32'd11,         4'b0000, 1'b0};
      tbl[10] = '{32'd15, 32'd10, 3'b011, 1'b0, 32'hFFFFFFF0,   4'b0000, 1'b0};
      tbl[11] = '{32'h7FFFFFFF, 32'd1, 3'b100, 1'b0, 32'h80000000, 4'b0010, 1'b0};
      tbl[12] = '{32'd1, 32'd35, 3'b101, 1'b0, 32'd8,           4'b0000, 1'b1};
      tbl[13] = '{32'h80000000, 32'd31, 3'b110, 1'b0, 32'd1,    4'b0000, 1'b1};
      tbl[14] = '{32'h80000000, 32'h80000000, 3'b100, 1'b0, 32'd0, 4'b1101, 1'b1};

      rst = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0;
      A = '0; B = '0; FS = '0; C0 = 1'b0; F = '0; status = '0;
      tick();
      tick();
      rst = 1'b0;

      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_pass", {31'd0, pass}, 32'd0);
      check("reset_vec_cnt", {16'd0, vec_cnt}, 32'd0);
      check("reset_err_cnt", {16'd0, err_cnt}, 32'd0);
      check("reset_skip_cnt", {16'd0, skip_cnt}, 32'd0);
      check("reset_fail_vec", fail_vec, 32'd0);
      check("reset_fail_F", fail_F, 32'd0);

      // One single-vector run per table entry.
      for (int i = 0; i < 15; i++) begin
         do_start();
         send(tbl[i].a, tbl[i].b, tbl[i].fs, tbl[i].c0, tbl[i].f, tbl[i].st, 1'b1);
         wait_done($sformatf("tbl%0d_done", i));
         check($sformatf("tbl%0d_pass", i), {31'd0, pass}, {31'd0, tbl[i].exp_pass});
         check($sformatf("tbl%0d_err", i), {16'd0, err_cnt}, {31'd0, !tbl[i].exp_pass});
         check($sformatf("tbl%0d_vec", i), {16'd0, vec_cnt}, 32'd1);
      end

      // Logic ops in one run.
      do_start();
      for (int i = 0; i < 4; i++) begin
         send(tbl[i].a, tbl[i].b, tbl[i].fs, tbl[i].c0, tbl[i].f, tbl[i].st, i == 3);
      end
      check("logic_busy_drain", {31'd0, busy}, 32'd1);
      check("logic_pass_early", {31'd0, pass}, 32'd0);
      wait_done("logic_done");
      check("logic_vec", {16'd0, vec_cnt}, 32'd4);
      check("logic_err", {16'd0, err_cnt}, 32'd0);
      check("logic_pass", {31'd0, pass}, 32'd1);
      check("logic_busy_done", {31'd0, busy}, 32'd0);

      // Shift run with a wrong result on the second vector.
      do_start();
      send(32'd2, 32'd1, 3'b101, 1'b0, 32'd4, 4'b0000, 1'b0);
      send(32'd2, 32'd1, 3'b110, 1'b0, 32'd3, 4'b0000, 1'b1);
      wait_done("shift_done");
      check("shift_err", {16'd0, err_cnt}, 32'd1);
      check("shift_fail_vec", fail_vec, 32'd1);
      check("shift_fail_F", fail_F, 32'd3);
      check("shift_fail_exp", fail_exp, 32'd1);
      check("shift_pass", {31'd0, pass}, 32'd0);

      // 100 back-to-back random vectors, errors at 10/50/90, skips elsewhere.
      exp10 = '0;
      do_start();
      for (int i = 0; i < 100; i++) begin
         ra  = $urandom;
         rb  = $urandom;
         rc0 = 1'($urandom_range(0, 1));
         rfs = 3'($urandom_range(0, 6));
         if (i == 20 || i == 30 || i == 40 || i == 60 || i == 70) rfs = 3'b111;
         g = golden(ra, rb, rfs, rc0);
         if (i == 10) exp10 = g[31:0];
         if (i == 10 || i == 50 || i == 90) g[0] = ~g[0];
         drive(ra, rb, rfs, rc0, g[31:0], g[35:32], i == 99);
         tick();
      end
      valid = 1'b0;
      last  = 1'b0;
      wait_done("rand_done");
      check("rand_vec", {16'd0, vec_cnt}, 32'd95);
      check("rand_skip", {16'd0, skip_cnt}, 32'd5);
      check("rand_err", {16'd0, err_cnt}, 32'd3);
      check("rand_fail_vec", fail_vec, 32'd10);
      check("rand_fail_F", fail_F, exp10 ^ 32'd1);
      check("rand_fail_exp", fail_exp, exp10);

      // Reset right after a sampled vector discards it.
      do_start();
      send(32'd15, 32'd10, 3'b000, 1'b0, 32'd99, 4'b0000, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("rst_vec", {16'd0, vec_cnt}, 32'd0);
      check("rst_err", {16'd0, err_cnt}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);

      // Vector while IDLE is ignored.
      send(32'd15, 32'd10, 3'b000, 1'b0, 32'd10, 4'b0000, 1'b1);
      tick();
      tick();
      check("idle_vec", {16'd0, vec_cnt}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Start and valid together: vector dropped.
      start = 1'b1;
      drive(32'd15, 32'd10, 3'b000, 1'b0, 32'd10, 4'b0000, 1'b0);
      tick();
      start = 1'b0;
      valid = 1'b0;
      tick();
      tick();
      check("startvalid_vec", {16'd0, vec_cnt}, 32'd0);
      check("startvalid_busy", {31'd0, busy}, 32'd1);
      send(32'd15, 32'd10, 3'b001, 1'b0, 32'd15, 4'b0000, 1'b1);
      wait_done("startvalid_done");
      check("startvalid_vec_end", {16'd0, vec_cnt}, 32'd1);
      check("startvalid_pass", {31'd0, pass}, 32'd1);

      // Saturation: 20 failing vectors.
      do_start();
      for (int i = 0; i < 20; i++) begin
         drive(32'd1, 32'd1, 3'b000, 1'b0, 32'd0, 4'b0000, i == 19);
         tick();
      end
      valid = 1'b0;
      last  = 1'b0;
      wait_done("sat_done");
      check("sat_err4", {28'd0, err_cnt4}, 32'd15);
      check("sat_vec4", {28'd0, vec_cnt4}, 32'd15);
      check("sat_pass4", {31'd0, pass4}, 32'd0);
      check("sat_err16", {16'd0, err_cnt}, 32'd20);
      check("sat_fail_vec", fail_vec, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
